// File: rtl/dm_block_mover_pkg.sv
// Shared definitions for the data-memory block mover: FSM state encoding and mode codes.
package dm_block_mover_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FILL = 2'd3
    } state_t;

    localparam logic COPY = 1'b0;
    localparam logic FILL = 1'b1;

endpackage

// File: rtl/SinglePortRAM.sv
// Single-port data-memory BRAM: synchronous write, registered address, combinational read-out.
module SinglePortRAM #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned FALL_EDGE = 0
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WORD_SIZE-1:0] d_i,
    output logic [WORD_SIZE-1:0] q_o
);

    logic [WORD_SIZE-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]    addr_r;

    generate
        if (FALL_EDGE != 0) begin : g_neg
            always_ff @(negedge clk_i) begin
                if (we_i) mem[addr_i] <= d_i;
                addr_r <= addr_i;
            end
        end else begin : g_pos
            always_ff @(posedge clk_i) begin
                if (we_i) mem[addr_i] <= d_i;
                addr_r <= addr_i;
            end
        end
    endgenerate

    assign q_o = mem[addr_r];

endmodule

// File: rtl/dm_block_mover.sv
// Block-transfer initiator for the AVR data memory: forward word-by-word copy or constant fill
// through the single-port RAM while the CPU is stalled.
module dm_block_mover
    import dm_block_mover_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [ADDR_W-1:0]    src_i,
    input  logic [ADDR_W-1:0]    dst_i,
    input  logic [ADDR_W-1:0]    len_i,
    input  logic [WORD_SIZE-1:0] fill_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ram_we_o,
    output logic [ADDR_W-1:0]    ram_addr_o,
    output logic [WORD_SIZE-1:0] ram_d_o,
    input  logic [WORD_SIZE-1:0] ram_d_i
);

    state_t               state;
    logic [ADDR_W-1:0]    src_r;
    logic [ADDR_W-1:0]    dst_r;
    logic [ADDR_W-1:0]    cnt_r;
    logic [WORD_SIZE-1:0] fill_r;
    logic                 done_r;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= S_IDLE;
            src_r  <= '0;
            dst_r  <= '0;
            cnt_r  <= '0;
            fill_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            src_r  <= src_i;
                            dst_r  <= dst_i;
                            cnt_r  <= len_i;
                            fill_r <= fill_i;
                            state  <= (mode_i == FILL) ? S_FILL : S_RD;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state <= abort_i ? S_IDLE : S_WR;
                end
                S_WR, S_FILL: begin
                    // The write decoded this cycle commits at this edge even when aborting.
                    dst_r <= dst_r + ADDR_W'(1);
                    if (state == S_WR) src_r <= src_r + ADDR_W'(1);
                    cnt_r <= cnt_r - ADDR_W'(1);
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (cnt_r == ADDR_W'(1)) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end else if (state == S_WR) begin
                        state <= S_RD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state != S_IDLE);
    assign done_o = done_r;

    // RAM port decoded from state only; WR forwards the word read in the preceding RD.
    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_d_o    = '0;
        case (state)
            S_RD: begin
                ram_addr_o = src_r;
            end
            S_WR: begin
                ram_we_o   = 1'b1;
                ram_addr_o = dst_r;
                ram_d_o    = ram_d_i;
            end
            S_FILL: begin
                ram_we_o   = 1'b1;
                ram_addr_o = dst_r;
                ram_d_o    = fill_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_block_mover.sv
// Scoreboard bench for dm_block_mover driving a SinglePortRAM through a busy-controlled port mux.
module tb_dm_block_mover;
    import dm_block_mover_pkg::*;

    localparam int unsigned WS = 8;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic [AW-1:0] src = '0, dst = '0, len = '0;
    logic [WS-1:0] fill = '0;
    logic          busy, done, m_we;
    logic [AW-1:0] m_addr;
    logic [WS-1:0] m_d, ram_q;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [WS-1:0] cpu_d = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [WS-1:0] ram_d;

    always #5 clk = ~clk;

    assign ram_we   = busy ? m_we   : cpu_we;
    assign ram_addr = busy ? m_addr : cpu_addr;
    assign ram_d    = busy ? m_d    : cpu_d;

    dm_block_mover #(.WORD_SIZE(WS), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
        .src_i(src), .dst_i(dst), .len_i(len), .fill_i(fill), .abort_i(abort),
        .busy_o(busy), .done_o(done), .ram_we_o(m_we), .ram_addr_o(m_addr),
        .ram_d_o(m_d), .ram_d_i(ram_q)
    );

    SinglePortRAM #(.WORD_SIZE(WS), .ADDR_W(AW), .FALL_EDGE(0)) u_ram (
        .clk_i(clk), .we_i(ram_we), .addr_i(ram_addr), .d_i(ram_d), .q_o(ram_q)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [WS-1:0] mdl [0:(1<<AW)-1];
    int unsigned   n_checks = 0, n_fail = 0;
    int unsigned   n_wr = 0, n_busy = 0, n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: every mover write must match the head of the expected queue.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst_n) begin
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                check("done_while_busy", 32'(busy), 0);
            end
            if (busy && m_we) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(m_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(m_addr), 32'(e.addr));
                    check("wr_data", 32'(m_d), 32'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [WS-1:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_d = d;
        tick();
        cpu_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [WS-1:0] d);
        cpu_addr = a;
        tick();
        d = ram_q;
    endtask

    task automatic check_mem(input string tag, input logic [AW-1:0] a, input logic [WS-1:0] exp);
        logic [WS-1:0] q;
        cpu_read(a, q);
        check(tag, 32'(q), 32'(exp));
    endtask

    task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int unsigned n);
        logic [AW-1:0] as, ad;
        for (int unsigned i = 0; i < n; i++) begin
            as = s + AW'(i);
            ad = d + AW'(i);
            mdl[ad] = mdl[as];
            exp_q.push_back('{addr: ad, data: mdl[ad]});
        end
    endtask

    task automatic push_fill(input logic [AW-1:0] d, input int unsigned n, input logic [WS-1:0] v);
        logic [AW-1:0] ad;
        for (int unsigned i = 0; i < n; i++) begin
            ad = d + AW'(i);
            mdl[ad] = v;
            exp_q.push_back('{addr: ad, data: v});
        end
    endtask

    task automatic start_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [AW-1:0] l, input logic [WS-1:0] f);
        mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned c;
        c = 0;
        while (busy && c < 20000) begin
            tick();
            c++;
        end
        if (busy) check(tag, 1, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned  b0, d0, w0;
        logic [WS-1:0] t1 [4];
        t1[0] = 8'hA1; t1[1] = 8'hB2; t1[2] = 8'hC3; t1[3] = 8'hD4;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(m_we), 0);
        check("rst_addr", 32'(m_addr), 0);
        check("rst_d", 32'(m_d), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Test 1: plain copy
        for (int i = 0; i < 4; i++) cpu_write(AW'(12'h100 + i), t1[i]);
        b0 = n_busy; d0 = n_done; w0 = n_wr;
        push_copy(12'h100, 12'h200, 4);
        start_xfer(COPY, 12'h100, 12'h200, 12'd4, 8'h00);
        check("t1_busy_start", 32'(busy), 1);
        wait_idle("t1_timeout");
        check("t1_done", 32'(done), 1);
        tick();
        check("t1_done_once", 32'(done), 0);
        check("t1_busy_cycles", n_busy - b0, 8);
        check("t1_done_count", n_done - d0, 1);
        check("t1_writes", n_wr - w0, 4);
        check("t1_queue", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) check_mem("t1_mem", AW'(12'h200 + i), t1[i]);

        // Test 2: fill wrapping the top of memory
        b0 = n_busy; d0 = n_done;
        push_fill(12'hFFE, 4, 8'h5A);
        start_xfer(FILL, 12'h000, 12'hFFE, 12'd4, 8'h5A);
        wait_idle("t2_timeout");
        check("t2_done", 32'(done), 1);
        tick();
        check("t2_busy_cycles", n_busy - b0, 4);
        check("t2_done_count", n_done - d0, 1);
        check("t2_queue", exp_q.size(), 0);
        check_mem("t2_mem_ffe", 12'hFFE, 8'h5A);
        check_mem("t2_mem_fff", 12'hFFF, 8'h5A);
        check_mem("t2_mem_000", 12'h000, 8'h5A);
        check_mem("t2_mem_001", 12'h001, 8'h5A);

        // Test 3: zero length
        b0 = n_busy; d0 = n_done; w0 = n_wr;
        start_xfer(COPY, 12'h100, 12'h300, 12'd0, 8'h00);
        check("t3_busy", 32'(busy), 0);
        check("t3_done", 32'(done), 1);
        tick();
        check("t3_done_once", 32'(done), 0);
        tick();
        check("t3_busy_cycles", n_busy - b0, 0);
        check("t3_done_count", n_done - d0, 1);
        check("t3_writes", n_wr - w0, 0);

        // Test 4: abort during the third write
        for (int i = 0; i < 8; i++) cpu_write(AW'(12'h300 + i), WS'(8'h10 + i));
        for (int i = 0; i < 8; i++) cpu_write(AW'(12'h400 + i), 8'hEE);
        b0 = n_busy; d0 = n_done; w0 = n_wr;
        push_copy(12'h300, 12'h400, 3);
        start_xfer(COPY, 12'h300, 12'h400, 12'd8, 8'h00);
        repeat (5) tick();
        check("t4_in_wr", 32'(m_we), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_idle", 32'(busy), 0);
        check("t4_no_done", 32'(done), 0);
        tick();
        check("t4_no_done_late", 32'(done), 0);
        check("t4_busy_cycles", n_busy - b0, 6);
        check("t4_done_count", n_done - d0, 0);
        check("t4_writes", n_wr - w0, 3);
        check("t4_queue", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) check_mem("t4_mem", AW'(12'h400 + i), (i < 3) ? WS'(8'h10 + i) : 8'hEE);

        // Test 5: overlapping forward copy propagates the first word
        for (int i = 0; i < 4; i++) cpu_write(AW'(12'h010 + i), WS'(i + 1));
        push_copy(12'h010, 12'h011, 3);
        start_xfer(COPY, 12'h010, 12'h011, 12'd3, 8'h00);
        wait_idle("t5_timeout");
        check("t5_done", 32'(done), 1);
        tick();
        check("t5_queue", exp_q.size(), 0);
        check_mem("t5_mem_10", 12'h010, 8'h01);
        check_mem("t5_mem_11", 12'h011, 8'h01);
        check_mem("t5_mem_12", 12'h012, 8'h01);
        check_mem("t5_mem_13", 12'h013, 8'h01);

        // Test 6: asynchronous reset in the middle of a fill
        for (int i = 0; i < 5; i++) cpu_write(AW'(12'h500 + i), 8'h00);
        push_fill(12'h500, 3, 8'h77);
        start_xfer(FILL, 12'h000, 12'h500, 12'd10, 8'h77);
        repeat (3) tick();
        check("t6_filling", 32'(m_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_we", 32'(m_we), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_addr", 32'(m_addr), 0);
        check("t6_rst_done", 32'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_queue", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) check_mem("t6_mem", AW'(12'h500 + i), (i < 3) ? 8'h77 : 8'h00);
        d0 = n_done;
        push_fill(12'h600, 2, 8'h33);
        start_xfer(FILL, 12'h000, 12'h600, 12'd2, 8'h33);
        check("t6_restart_busy", 32'(busy), 1);
        wait_idle("t6_timeout");
        check("t6_restart_done", 32'(done), 1);
        tick();
        check("t6_done_count", n_done - d0, 1);
        check("t6_restart_queue", exp_q.size(), 0);
        check_mem("t6_mem_600", 12'h600, 8'h33);
        check_mem("t6_mem_601", 12'h601, 8'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
